// File: rtl/slow_clk_meter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : slow_clk_meter_pkg
//  Description : Shared state encoding and default constants for the slow
//                clock meter and the divider-instance wrappers around it.
//  Revision    : 1.0  initial release
// ============================================================================
package slow_clk_meter_pkg;

    // Default measurement constants (toggle divider, ~800 kHz output)
    localparam int c_cnt_w       = 16;
    localparam int c_sync_stages = 2;
    localparam int c_exp_period  = 252;
    localparam int c_tol         = 2;
    localparam int c_timeout     = 1023;
    localparam int c_lock_n      = 4;

    // Measurement FSM state encoding
    localparam int         c_st_w         = 2;
    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_wait_rise = 2'd1;
    localparam logic [1:0] c_st_measure   = 2'd2;

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : sync_edge_det
//  Description : Multi-flop synchronizer for an asynchronous level, followed by
//                a delay flop giving single-cycle rise/fall strobes.
//  Revision    : 1.0  initial release
// ============================================================================
module sync_edge_det #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_dly;

    // Shift the async input through the synchronizer, then one delay stage
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_dly  <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_dly  <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_level = r_sync[SYNC_STAGES-1];
    assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_dly;
    assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_dly;

endmodule
`default_nettype wire

// File: rtl/slow_clk_meter.sv
`default_nettype none
// ============================================================================
//  Module      : slow_clk_meter
//  Description : Measures period and high time of a slow divided clock in
//                system-clock cycles, flags tolerance violations and stopped
//                clocks, and reports lock after consecutive good periods.
//  Revision    : 1.0  initial release
// ============================================================================
module slow_clk_meter
    import slow_clk_meter_pkg::*;
#(
    parameter int CNT_W       = c_cnt_w,
    parameter int SYNC_STAGES = c_sync_stages,
    parameter int EXP_PERIOD  = c_exp_period,
    parameter int TOL         = c_tol,
    parameter int TIMEOUT     = c_timeout,
    parameter int LOCK_N      = c_lock_n
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_in,
    input  logic             en,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             period_valid,
    output logic             in_range,
    output logic             lock,
    output logic             timeout
);

    localparam int               c_lock_w    = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] c_lo        = CNT_W'(EXP_PERIOD - TOL);
    localparam logic [CNT_W-1:0] c_hi        = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0] c_to        = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);
    localparam logic [c_lock_w-1:0] c_lock_full = c_lock_w'(LOCK_N);
    localparam logic [c_lock_w-1:0] c_lock_last = c_lock_w'(LOCK_N - 1);

    logic                w_rise;
    logic                w_fall;
    logic                w_in_range;
    logic                w_timeout_hit;
    logic [c_st_w-1:0]   r_state;
    logic [c_st_w-1:0]   w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    r_high_cap;
    logic [CNT_W-1:0]    r_period;
    logic [CNT_W-1:0]    r_high_time;
    logic                r_period_valid;
    logic                r_in_range;
    logic                r_lock;
    logic                r_timeout;
    logic [c_lock_w-1:0] r_lock_cnt;

    sync_edge_det #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge_det (
        .clk     (clk),
        .i_rst_n (reset),
        .i_async (s_in),
        .o_level (),
        .o_rise  (w_rise),
        .o_fall  (w_fall)
    );

    assign w_in_range = (r_cnt >= c_lo) && (r_cnt <= c_hi);

    // Next-state logic; a rise coinciding with the timeout count is measured
    always_comb begin
        w_state_next  = r_state;
        w_timeout_hit = 1'b0;
        if (!en) begin
            w_state_next = c_st_idle;
        end else begin
            case (r_state)
                c_st_idle:      w_state_next = c_st_wait_rise;
                c_st_wait_rise: if (w_rise) w_state_next = c_st_measure;
                c_st_measure: begin
                    if (!w_rise && (r_cnt == c_to)) begin
                        w_state_next  = c_st_wait_rise;
                        w_timeout_hit = 1'b1;
                    end
                end
                default:        w_state_next = c_st_idle;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= c_st_idle;
        else        r_state <= w_state_next;
    end

    // Period counter, capture registers, lock tracking and timeout flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt          <= '0;
            r_high_cap     <= '0;
            r_period       <= '0;
            r_high_time    <= '0;
            r_period_valid <= 1'b0;
            r_in_range     <= 1'b0;
            r_lock         <= 1'b0;
            r_timeout      <= 1'b0;
            r_lock_cnt     <= '0;
        end else begin
            r_period_valid <= 1'b0;
            if (!en) begin
                // Results hold while disabled; health flags restart from scratch
                r_lock     <= 1'b0;
                r_timeout  <= 1'b0;
                r_lock_cnt <= '0;
            end else if (r_state == c_st_wait_rise) begin
                if (w_rise) begin
                    r_cnt     <= c_one;
                    r_timeout <= 1'b0;
                end
            end else if (r_state == c_st_measure) begin
                if (w_rise) begin
                    r_cnt          <= c_one;
                    r_period       <= r_cnt;
                    r_high_time    <= r_high_cap;
                    r_in_range     <= w_in_range;
                    r_period_valid <= 1'b1;
                    if (w_in_range) begin
                        if (r_lock_cnt != c_lock_full) r_lock_cnt <= r_lock_cnt + 1'b1;
                        r_lock <= (r_lock_cnt >= c_lock_last);
                    end else begin
                        r_lock_cnt <= '0;
                        r_lock     <= 1'b0;
                    end
                end else if (w_timeout_hit) begin
                    r_timeout  <= 1'b1;
                    r_lock     <= 1'b0;
                    r_lock_cnt <= '0;
                end else begin
                    if (r_cnt != '1) r_cnt <= r_cnt + c_one;
                    if (w_fall)      r_high_cap <= r_cnt;
                end
            end
        end
    end

    assign period       = r_period;
    assign high_time    = r_high_time;
    assign period_valid = r_period_valid;
    assign in_range     = r_in_range;
    assign lock         = r_lock;
    assign timeout      = r_timeout;

endmodule
`default_nettype wire
